// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S transmit path.
package i2s_pkg;

   localparam int FRAME_BITS = 64;
   localparam int SLOT_BITS  = 32;
   localparam int POSN_W     = 6;

   // Frame position at which the next stereo frame is loaded for serialisation.
   localparam logic [POSN_W-1:0] LOAD_POSN = POSN_W'(FRAME_BITS - 1);

   // True when slot bit position b carries sample data (I2S one-bit delay:
   // bit 0 of a slot is always idle, data occupies 1..width).
   function automatic logic slot_active(input logic [4:0] b, input int unsigned width);
      return (b != 5'd0) && (32'(b) <= width);
   endfunction

endpackage

// File: rtl/i2s_frame_fifo.sv
// Stereo-frame FIFO: DEPTH entries of {left, right}, power-of-two depth.
module i2s_frame_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
) (
   input  logic               ck,
   input  logic               rst_n,
   input  logic               push,
   input  logic [2*WIDTH-1:0] wdata,
   input  logic               pop,
   output logic [2*WIDTH-1:0] rdata,
   output logic               full,
   output logic               empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [2*WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        occ;
   logic               do_push;
   logic               do_pop;

   // Requests are gated here so callers may assert push/pop unconditionally.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   assign full  = (occ == (AW+1)'(DEPTH));
   assign empty = (occ == '0);
   assign rdata = mem[rd_ptr];

   // Storage array; contents are don't-care while empty, so no reset.
   always_ff @(posedge ck) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

   // Pointers wrap naturally at DEPTH; occupancy tracks 0..DEPTH.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: buffers stereo frames and serialises them MSB-first with
// the one-bit I2S delay, driven by an external bit strobe and frame position.
module i2s_tx
   import i2s_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
) (
   input  logic              ck,
   input  logic              rst_n,
   input  logic              en,
   input  logic [POSN_W-1:0] frame_posn,
   input  logic [WIDTH-1:0]  left,
   input  logic [WIDTH-1:0]  right,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              sd,
   output logic              underrun
);

   logic [2*WIDTH-1:0] hold;
   logic [2*WIDTH-1:0] head;
   logic               fifo_full;
   logic               fifo_empty;
   logic               load;
   logic [4:0]         bpos;
   logic [WIDTH-1:0]   slot;
   logic [WIDTH-1:0]   slot_shr;
   logic [4:0]         shamt;
   logic               bit_nxt;

   assign in_ready = ~fifo_full;

   // Load point: last bit of the frame, only when the strobe is present.
   assign load = en && (frame_posn == LOAD_POSN);

   i2s_frame_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .ck    (ck),
      .rst_n (rst_n),
      .push  (in_valid),
      .wdata ({left, right}),
      .pop   (load),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Bit select: choose the slot half, then shift the wanted bit down to
   // position 0 (a shift keeps the index width independent of WIDTH).
   always_comb begin
      bpos     = frame_posn[4:0];
      slot     = frame_posn[POSN_W-1] ? hold[WIDTH-1:0] : hold[2*WIDTH-1:WIDTH];
      shamt    = 5'(WIDTH) - bpos;
      slot_shr = slot >> shamt;
      bit_nxt  = slot_active(bpos, WIDTH) ? slot_shr[0] : 1'b0;
   end

   // Serialiser: sd, hold and underrun move only on the bit strobe; the load
   // replaces hold in the same cycle sd takes its last bit from the old frame.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         sd       <= 1'b0;
         hold     <= '0;
         underrun <= 1'b0;
      end else begin
         underrun <= 1'b0;
         if (en)
            sd <= bit_nxt;
         if (load) begin
            // A push in this same cycle is not visible yet: empty means silence.
            hold     <= fifo_empty ? '0 : head;
            underrun <= fifo_empty;
         end
      end
   end

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: a queue-based frame model predicts sd,
// underrun and in_ready per cycle; a negedge monitor compares.
module tb_i2s_tx;

   localparam int W = 16;
   localparam int D = 2;

   typedef struct {
      int tag;
      bit rdy;
      bit chk_sd;
   } rdy_t;

   typedef struct {
      int tag;
      bit sd;
      bit unr;
   } out_t;

   logic          ck = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic [5:0]    frame_posn = '0;
   logic [W-1:0]  left = '0;
   logic [W-1:0]  right = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          sd;
   logic          underrun;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;

   rdy_t          rdyq[$];
   out_t          outq[$];
   logic [31:0]   send_q[$];
   logic [31:0]   mq[$];
   logic [31:0]   m_hold = '0;
   bit            m_sd = 1'b0;
   bit            m_unr = 1'b0;
   logic [5:0]    posn = '0;
   bit            rand_valid = 1'b0;
   bit            arm63 = 1'b0;
   logic [31:0]   arm_fr = '0;
   int            unr_seen = 0;

   i2s_tx #(.WIDTH(W), .DEPTH(D)) dut (
      .ck         (ck),
      .rst_n      (rst_n),
      .en         (en),
      .frame_posn (frame_posn),
      .left       (left),
      .right      (right),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .sd         (sd),
      .underrun   (underrun)
   );

   always #5 ck = ~ck;

   // One bench cycle: drive inputs just after the edge and record what the
   // model says the DUT must show before and after the next edge.
   task automatic drive(input bit e);
      bit          v;
      bit          rdy;
      logic [15:0] s;
      int          b;
      @(posedge ck);
      #1;
      cyc++;
      rst_n = 1'b1;
      if (arm63 && e && posn == 6'd63 && mq.size() == 0) begin
         send_q.push_back(arm_fr);
         arm63 = 1'b0;
      end
      v = (send_q.size() != 0) && (!rand_valid || $urandom_range(0, 3) != 0);
      en = e;
      frame_posn = posn;
      in_valid = v;
      if (send_q.size() != 0)
         {left, right} = send_q[0];
      else
         {left, right} = $urandom;
      rdy = (mq.size() < D);
      rdyq.push_back('{cyc, rdy, 1'b0});
      m_unr = 1'b0;
      if (e) begin
         b = int'(posn % 32);
         s = (posn >= 6'd32) ? m_hold[15:0] : m_hold[31:16];
         m_sd = (b >= 1 && b <= W) ? bit'((s >> (W - b)) & 16'd1) : 1'b0;
         if (posn == 6'd63) begin
            m_unr = (mq.size() == 0);
            m_hold = m_unr ? 32'd0 : mq.pop_front();
         end
         posn = posn + 6'd1;
      end
      if (v && rdy)
         mq.push_back(send_q.pop_front());
      outq.push_back('{cyc, m_sd, m_unr});
   endtask

   // Asynchronous reset asserted mid-cycle, away from the clock edge.
   task automatic rst_cycle();
      @(posedge ck);
      #1;
      cyc++;
      rst_n = 1'b0;
      en = 1'b0;
      in_valid = 1'b0;
      frame_posn = posn;
      mq.delete();
      send_q.delete();
      m_hold = '0;
      m_sd = 1'b0;
      m_unr = 1'b0;
      if (outq.size() != 0) begin
         outq[outq.size()-1].sd = 1'b0;
         outq[outq.size()-1].unr = 1'b0;
      end
      rdyq.push_back('{cyc, 1'b1, 1'b1});
      outq.push_back('{cyc, 1'b0, 1'b0});
   endtask

   task automatic run_bits(input int n, input int lo, input int hi);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(lo, hi) - 1) drive(1'b0);
         drive(1'b1);
      end
   endtask

   task automatic run_to(input logic [5:0] target);
      for (int i = 0; i < 200 && posn != target; i++)
         run_bits(1, 2, 2);
   endtask

   // Monitor: in_ready (and sd under reset) for the current cycle, then
   // sd/underrun produced by the previous edge.
   always @(negedge ck) begin
      while (rdyq.size() != 0 && rdyq[0].tag <= cyc) begin
         rdy_t r;
         r = rdyq.pop_front();
         checks++;
         if (in_ready !== r.rdy) begin
            errors++;
            $display("FAIL in_ready cyc=%0d: got %b expected %b", r.tag, in_ready, r.rdy);
         end
         if (r.chk_sd) begin
            checks++;
            if (sd !== 1'b0 || underrun !== 1'b0) begin
               errors++;
               $display("FAIL reset_out cyc=%0d: got sd=%b unr=%b expected 0/0", r.tag, sd, underrun);
            end
         end
      end
      while (outq.size() != 0 && outq[0].tag <= cyc - 1) begin
         out_t o;
         o = outq.pop_front();
         checks++;
         if (sd !== o.sd || underrun !== o.unr) begin
            errors++;
            $display("FAIL sd_unr cyc=%0d posn_in=%0d: got sd=%b unr=%b expected sd=%b unr=%b",
                     o.tag, frame_posn, sd, underrun, o.sd, o.unr);
         end
         if (o.unr)
            unr_seen++;
      end
   end

   initial begin
      // Reset state.
      repeat (3) rst_cycle();

      // Idle frames at a slow divider: silence, one underrun per frame.
      unr_seen = 0;
      run_bits(3 * 64, 12, 12);
      repeat (2) drive(1'b0);
      checks++;
      if (unr_seen != 3) begin
         errors++;
         $display("FAIL idle_underruns: got %0d expected 3", unr_seen);
      end

      // Known pattern pushed mid-frame, serialised on the following frame.
      run_to(6'd40);
      send_q.push_back({16'hA5C3, 16'h8001});
      run_bits(2 * 64 + 10, 2, 2);

      // Three back-to-back frames into a two-deep FIFO.
      for (int i = 0; i < 3; i++)
         send_q.push_back($urandom);
      run_bits(5 * 64, 2, 2);

      // Push coinciding with the load on an empty FIFO.
      arm_fr = $urandom;
      arm63 = 1'b1;
      run_bits(3 * 64, 2, 2);
      checks++;
      if (arm63) begin
         errors++;
         $display("FAIL push_at_load: got armed=1 expected 0");
      end
      arm63 = 1'b0;

      // Reset mid right slot with two frames queued.
      run_to(6'd1);
      send_q.push_back($urandom);
      send_q.push_back($urandom);
      run_to(6'd40);
      rst_cycle();
      rst_cycle();
      run_bits(2 * 64, 2, 2);
      send_q.push_back($urandom);
      run_bits(2 * 64, 2, 2);

      // Irregular strobe with long stalls and random producer.
      rand_valid = 1'b1;
      for (int i = 0; i < 12; i++)
         send_q.push_back($urandom);
      for (int f = 0; f < 10; f++) begin
         run_bits(30, 1, 6);
         repeat (40) drive(1'b0);
         run_bits(34, 1, 4);
      end
      rand_valid = 1'b0;

      repeat (3) drive(1'b0);
      @(negedge ck);
      @(negedge ck);
      checks++;
      if (outq.size() > 1 || rdyq.size() > 1) begin
         errors++;
         $display("FAIL drain: got outq=%0d rdyq=%0d expected <=1", outq.size(), rdyq.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set bits per channel sample; legal range 1..31.
REQ-002 Parameter DEPTH, default 2, SHALL set stereo-frame FIFO depth; power of two, at least 2.
REQ-003 Port ck, input, 1: single system clock; all state SHALL be clocked on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port en, input, 1: one-ck strobe marking each new bit period, from i2s_clock, i2s_secondary or i2s_dual.
REQ-006 Port frame_posn, input, 6: bit position in a 64-bit frame; 0..31 is the left slot, 32..63 the right slot.
REQ-007 Port left, input, WIDTH: left-channel sample, two's complement.
REQ-008 Port right, input, WIDTH: right-channel sample, two's complement.
REQ-009 Port in_valid, input, 1: left and right hold a frame for transfer.
REQ-010 Port in_ready, output, 1: the FIFO can accept a frame.
REQ-011 Port sd, output, 1: I2S serial data.
REQ-012 Port underrun, output, 1: one-ck pulse when a frame load finds the FIFO empty.

Function
REQ-013 Transfer: a frame SHALL be pushed on any ck where in_valid and in_ready are both 1; in_ready SHALL equal "FIFO not full".
REQ-014 in_valid asserted while in_ready is 0 SHALL leave the FIFO unchanged; no data is dropped or overwritten.
REQ-015 Hold register: a 2*WIDTH register SHALL hold the frame currently being serialised.
REQ-016 Bit select, on every ck with en=1:
  - Let b = frame_posn[4:0] and s = hold register left half if frame_posn[5]=0, else right half.
  - If 1 <= b <= WIDTH: sd SHALL be loaded with s[WIDTH-b], so the MSB goes out one bit after the slot boundary (I2S delay).
  - Otherwise: sd SHALL be loaded with 0.
REQ-017 sd SHALL change only on ck cycles with en=1; latency from en to the new sd value SHALL be 1 ck.
REQ-018 Frame load: on en=1 with frame_posn=63, the hold register SHALL be loaded in the same ck as sd is computed from the old hold-register contents.
  - FIFO not empty: load the FIFO head and pop it.
  - FIFO empty: load all zeros and assert underrun for exactly that ck.
REQ-019 Push and load in the same ck:
  - FIFO empty: the load SHALL see empty (no bypass), raise underrun, and the pushed frame SHALL be stored.
  - FIFO full: no push occurs (in_ready is 0) and the pop SHALL proceed.
REQ-020 FIFO read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL count 0..DEPTH.
REQ-021 Non-monotonic frame_posn (for example a relock) SHALL get no special handling; loads happen only at posn 63.
REQ-022 en=0 SHALL freeze sd, the hold register and the load logic; FIFO pushes SHALL continue.

Reset
REQ-023 rst_n=0 SHALL asynchronously clear the FIFO to empty, the hold register to 0, sd to 0 and underrun to 0; in_ready SHALL be 1 after reset.
REQ-024 rst_n=0 in mid-frame SHALL discard all stored and in-flight data; after release, output SHALL be zeros until the next posn-63 load.

Structure
REQ-025 Package i2s_pkg SHALL hold FRAME_BITS=64, SLOT_BITS=32 and the frame_posn width (6).
REQ-026 The FIFO SHALL be a sub-module i2s_frame_fifo (parameters WIDTH and DEPTH; push/pop/full/empty).
REQ-027 The serialiser, with hold register and bit select, SHALL live in i2s_tx.

Verification
REQ-028 Reset release with no pushes, driven by i2s_clock DIVIDER=12 -> sd stays 0 for 3 frames; underrun pulses once per frame at posn 63.
REQ-029 Push L=16'hA5C3, R=16'h8001 before posn 63 -> next frame: sd = 0 at posn 0, A5C3 MSB-first at posn 1..16, 0 at 17..32, 8001 at 33..48, 0 at 49..63.
REQ-030 Push 3 frames back-to-back with DEPTH=2 -> in_ready drops after 2 pushes; the third transfers after the first posn-63 pop; frames appear in push order.
REQ-031 Push in the same ck as a posn-63 load with the FIFO empty -> underrun=1 and the frame is serialised one frame later.
REQ-032 rst_n low for 2 ck mid-right-slot with 2 frames queued -> sd=0 immediately and in_ready=1; after release, sd=0 until a new push is loaded.
REQ-033 Drive from i2s_dual with ext_sck stopping mid-frame -> sd still matches the reference model bit-for-bit against frame_posn under en.
